// File: rtl/tw_gen_sdf_if.sv
// Sample-stream/twiddle bundle between an SDF butterfly stage and its twiddle generator.
// The generator sits on the slave side; the stage controller is the master.
interface tw_gen_sdf_if #(
  parameter int TW_W = 12
);
  logic                   in_valid;
  logic                   sof;
  logic                   inverse;
  logic signed [TW_W-1:0] tw_re;
  logic signed [TW_W-1:0] tw_im;
  logic                   tw_valid;
  logic                   tw_bypass;
  logic                   tw_last;

  modport master (
    output in_valid, sof, inverse,
    input  tw_re, tw_im, tw_valid, tw_bypass, tw_last
  );

  modport slave (
    input  in_valid, sof, inverse,
    output tw_re, tw_im, tw_valid, tw_bypass, tw_last
  );
endinterface

// File: rtl/tw_gen_sdf.sv
// Twiddle-factor generator for one radix-2 DIF SDF stage: tracks the sample position
// in the stage's butterfly block and emits W_N^m from a quarter-wave cosine ROM.
module tw_gen_sdf #(
  parameter int N_LOG2 = 4,
  parameter int STAGE  = 0,
  parameter int TW_W   = 12
) (
  input  logic         clk,
  input  logic         rst,
  tw_gen_sdf_if.slave  bus
);

  localparam int  N     = 1 << N_LOG2;
  localparam int  CW    = N_LOG2 - STAGE;
  localparam int  L     = 1 << CW;
  localparam int  H     = L / 2;
  localparam int  IW    = N_LOG2 - 1;
  localparam int  QTR   = N / 4;
  localparam int  HALF  = N / 2;
  localparam int  ROM_D = 1 << IW;
  localparam real PI    = 3.14159265358979323846;
  localparam real MAX_R = real'((longint'(1) << (TW_W - 1)) - 1);

  // Taylor series; the angle never exceeds pi/2, so 12 terms are far below 1 LSB.
  function automatic real cos_r(input real x);
    real term;
    real sum;
    term = 1.0;
    sum  = 1.0;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k - 1) * (2 * k));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // int'() of a real rounds to nearest with ties away from zero.
  function automatic int rom_val(input int k);
    return int'(MAX_R * cos_r(2.0 * PI * real'(k) / real'(N)));
  endfunction

  function automatic logic signed [TW_W-1:0] apply_sign(input logic signed [TW_W-1:0] v,
                                                        input logic                   neg);
    return neg ? -v : v;
  endfunction

  logic signed [TW_W-1:0] rom [ROM_D];

  for (genvar k = 0; k < ROM_D; k++) begin : g_rom
    if (k <= QTR) begin : g_val
      localparam int CV = rom_val(k);
      assign rom[k] = TW_W'(CV);
    end else begin : g_pad
      assign rom[k] = '0;
    end
  end

  logic [CW-1:0]     cnt;
  logic              inv_q;
  logic              accept_sof;
  logic [CW-1:0]     pos;
  logic [N_LOG2-1:0] pos_ext;
  logic [IW-1:0]     m;
  logic [IW-1:0]     idx_re_c;
  logic [IW-1:0]     idx_im_c;
  logic              neg_re_c;
  logic              neg_im_c;
  logic              inv_c;
  logic              bypass_c;
  logic              last_c;

  assign accept_sof = bus.sof & bus.in_valid;

  always_comb begin
    pos      = accept_sof ? '0 : cnt;
    inv_c    = accept_sof ? bus.inverse : inv_q;
    pos_ext  = N_LOG2'(pos);
    bypass_c = (pos_ext < N_LOG2'(H));
    last_c   = (pos == CW'(L - 1));
    m        = '0;
    if (!bypass_c) m = IW'((pos_ext - N_LOG2'(H)) << STAGE);
    if (int'(m) <= QTR) begin
      idx_re_c = m;
      neg_re_c = 1'b0;
      idx_im_c = IW'(QTR - int'(m));
    end else begin
      idx_re_c = IW'(HALF - int'(m));
      neg_re_c = 1'b1;
      idx_im_c = IW'(int'(m) - QTR);
    end
    // Forward twiddles always carry a non-positive imaginary part; IFFT conjugates.
    neg_im_c = ~inv_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      inv_q <= 1'b0;
    end else if (bus.in_valid) begin
      cnt   <= pos + CW'(1);
      inv_q <= inv_c;
    end
  end

  // ---- stage 1: ROM indices and sign flags ----
  logic          vld_p1;
  logic [IW-1:0] idx_re_p1;
  logic [IW-1:0] idx_im_p1;
  logic          neg_re_p1;
  logic          neg_im_p1;
  logic          bypass_p1;
  logic          last_p1;

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      idx_re_p1 <= idx_re_c;
      idx_im_p1 <= idx_im_c;
      neg_re_p1 <= neg_re_c;
      neg_im_p1 <= neg_im_c;
      bypass_p1 <= bypass_c;
      last_p1   <= last_c;
    end
  end

  // ---- stage 2: ROM read with sign applied; outputs hold between valid samples ----
  logic                   vld_p2;
  logic signed [TW_W-1:0] re_p2;
  logic signed [TW_W-1:0] im_p2;
  logic                   bypass_p2;
  logic                   last_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      re_p2     <= '0;
      im_p2     <= '0;
      bypass_p2 <= 1'b0;
      last_p2   <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        re_p2     <= apply_sign(rom[idx_re_p1], neg_re_p1);
        im_p2     <= apply_sign(rom[idx_im_p1], neg_im_p1);
        bypass_p2 <= bypass_p1;
        last_p2   <= last_p1;
      end
    end
  end

  assign bus.tw_re     = re_p2;
  assign bus.tw_im     = im_p2;
  assign bus.tw_valid  = vld_p2;
  assign bus.tw_bypass = bypass_p2;
  assign bus.tw_last   = last_p2;

endmodule

// File: doc/tw_gen_sdf.md
Name: tw_gen_sdf

Overview:
- Parametrised twiddle-factor generator for one stage of the radix-2 DIF single-path delay-feedback FFT pipeline.
- One instance per stage. Tracks the sample position inside the stage's butterfly block and emits W_N^m for every accepted sample.
- Coefficients come from a quarter-wave cosine ROM built at elaboration time. Forward or inverse (conjugate) mode is selected per frame.
- Replaces fixed per-stage case tables: any N, stage index and coefficient width from one module.

Parameters:
- N_LOG2, 4, log2 of FFT length N (N = 2^N_LOG2, N_LOG2 >= 2).
- STAGE, 0, stage index s, 0 .. N_LOG2-1.
- TW_W, 12, signed twiddle width; amplitude MAX = 2^(TW_W-1)-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  one sample enters the stage this cycle; advances the position counter
- sof  in  1  start of frame; qualified by in_valid; forces the position to 0
- inverse  in  1  IFFT mode; sampled on sof & in_valid
- tw_re  out  TW_W  signed real twiddle
- tw_im  out  TW_W  signed imaginary twiddle
- tw_valid  out  1  tw_re/tw_im valid for the sample that entered 2 cycles earlier
- tw_bypass  out  1  sample is in the first half of its block (twiddle is unity)
- tw_last  out  1  sample is the last of its block

Behaviour:
- Block length L = N >> STAGE, half H = L/2, counter cnt has width N_LOG2-STAGE.
- Position pos of the current sample:
  - if sof & in_valid: pos = 0;
  - else if in_valid: pos = cnt.
- On in_valid, cnt <= pos+1 mod L (wrap-around at L-1 -> 0). Without in_valid, cnt holds. Gaps are allowed; position continuity holds across gaps.
- inv_q <= inverse on sof & in_valid; otherwise inv_q holds. The sof-cycle sample already uses the new inverse value.
- Angle index:
  - pos < H: m = 0, bypass = 1.
  - pos >= H: m = (pos-H) << STAGE, range 0 .. N/2-1, bypass = 0.
- ROM C[k] = round(MAX*cos(2*pi*k/N)) for k = 0..N/4, computed with real arithmetic at elaboration. Rounding is half away from zero.
- Symmetry decode:
  - m <= N/4: re = C[m], im = -C[N/4-m].
  - m > N/4: re = -C[N/2-m], im = -C[m-N/4].
  - If inv_q: im is negated.
  - No value exceeds ±MAX, so negation never overflows.
- Pipeline, latency 2 cycles:
  - Stage 1 registers the ROM indices, negate flags, valid, bypass and last (last = pos == L-1).
  - Stage 2 registers the ROM reads with sign applied and drives the outputs.
- tw_valid follows in_valid exactly 2 cycles later.
- When tw_valid = 0, tw_re/tw_im/tw_bypass/tw_last hold their last values.
- Reset: tw_re = 0, tw_im = 0, tw_valid = 0, tw_bypass = 0, tw_last = 0, cnt = 0, inv_q = 0, pipeline valids cleared.
  - Reset mid-frame discards in-flight samples. The next accepted sample takes pos 0 even without sof.
- sof mid-block: the position resynchronises to 0 immediately. The samples already in flight still complete with their old positions.
- sof without in_valid has no effect.
- STAGE = N_LOG2-1: L = 2, m is always 0, so outputs are (MAX,0) for every sample; tw_bypass alternates 1,0.

Test Plan:
- N_LOG2=4, STAGE=0, TW_W=12; 16 back-to-back in_valid starting with sof, inverse=0 -> first 8 outputs (2047,0) with bypass=1. Next 8 outputs with bypass=0: (2047,0), (1891,-783), (1447,-1447), (783,-1891), (0,-2047), (-783,-1891), (-1447,-1447), (-1891,-783). tw_last on the 16th output. First tw_valid 2 cycles after the first in_valid.
- STAGE=1, same stream -> blocks of 8; the second half of each block gives (2047,0), (1447,-1447), (0,-2047), (-1447,-1447). tw_last on the 8th and 16th outputs.
- inverse=1 sampled with sof, STAGE=0 -> imaginary parts positive: position 9 gives (1891,783), position 12 gives (0,2047). Raising inverse mid-frame without sof -> no change in sign.
- in_valid toggling 1,0,0,1 through a frame -> output sequence identical to the back-to-back case; tw_valid mirrors the in_valid pattern delayed by 2 cycles; outputs hold during gaps.
- Mid-frame sof at position 5 -> that sample reports pos 0 (bypass=1, (2047,0)), and the following sequence restarts. Separately, rst asserted at position 10 for 1 cycle -> all outputs 0 the next cycle; the first accepted sample after reset is pos 0.
- STAGE=3 (L=2) -> every output is (2047,0); bypass alternates 1,0; tw_last is asserted on every second output.
